// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared op encodings, state enum and status bit positions for alu_exec_stage
package alu_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_MVN = 3'b011;
    localparam logic [2:0] ALU_MUL = 3'b100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int ST_V = 2;
    localparam int ST_N = 1;
    localparam int ST_Z = 0;

endpackage

// File: rtl/mul_iter.sv
// rtl/mul_iter.sv - iterative unsigned shift-add multiplier, one multiplier bit per cycle LSB-first
module mul_iter #(
    parameter int K       = 16,
    parameter int MUL_CYC = K
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [K-1:0]   a,
    input  logic [K-1:0]   b,
    output logic           last,
    output logic [2*K-1:0] product
);

    localparam int CW = $clog2(MUL_CYC + 1);

    logic           busy;
    logic [2*K-1:0] acc;
    logic [2*K-1:0] mcand;
    logic [K-1:0]   mplier;
    logic [CW-1:0]  cnt;
    logic [2*K-1:0] acc_nxt;

    assign acc_nxt = acc + (mplier[0] ? mcand : '0);
    // product is the accumulator including this cycle's partial term, so the
    // parent can capture it on the same edge that processes the final bit
    assign product = acc_nxt;
    assign last    = busy && (cnt == CW'(MUL_CYC - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy   <= 1'b0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else if (start) begin
            busy   <= 1'b1;
            acc    <= '0;
            mcand  <= {{K{1'b0}}, a};
            mplier <= b;
            cnt    <= '0;
        end else if (busy) begin
            acc    <= acc_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
            if (last) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_exec_stage.sv
// rtl/alu_exec_stage.sv - ALU execute stage with valid/ready handshake; ALU_MUL_EN adds iterative multiply
module alu_exec_stage
    import alu_pkg::*;
#(
    parameter int K       = 16,
    parameter int MUL_CYC = K
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [K-1:0] ain,
    input  logic [K-1:0] bin,
    input  logic [2:0]   op,
    input  logic         setf,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [K-1:0] c,
    output logic [2:0]   status
);

    state_t       state;
    logic         accept;
    logic [K-1:0] res;
    logic         res_v;

    assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
    assign accept   = in_valid && in_ready;

    // reserved ops fall through with res=0 so Z reports set
    always_comb begin
        res   = '0;
        res_v = 1'b0;
        case (op)
            ALU_ADD: begin
                res   = ain + bin;
                res_v = (ain[K-1] == bin[K-1]) && (res[K-1] != ain[K-1]);
            end
            ALU_SUB: begin
                res   = ain - bin;
                res_v = (ain[K-1] != bin[K-1]) && (res[K-1] != ain[K-1]);
            end
            ALU_AND: res = ain & bin;
            ALU_MVN: res = ~bin;
            default: ;
        endcase
    end

`ifdef ALU_MUL_EN
    logic           mul_last;
    logic [2*K-1:0] mul_prod;
    logic           setf_q;

    mul_iter #(
        .K       (K),
        .MUL_CYC (MUL_CYC)
    ) u_mul (
        .clk     (clk),
        .rst     (reset),
        .start   (accept && (op == ALU_MUL)),
        .a       (ain),
        .b       (bin),
        .last    (mul_last),
        .product (mul_prod)
    );
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            c         <= '0;
            status    <= 3'b000;
            out_valid <= 1'b0;
`ifdef ALU_MUL_EN
            setf_q    <= 1'b0;
`endif
        end else if (accept) begin
`ifdef ALU_MUL_EN
            if (op == ALU_MUL) begin
                state     <= BUSY;
                out_valid <= 1'b0;
                setf_q    <= setf;
            end else
`endif
            begin
                state     <= DONE;
                out_valid <= 1'b1;
                c         <= res;
                if (setf) begin
                    status[ST_V] <= res_v;
                    status[ST_N] <= res[K-1];
                    status[ST_Z] <= ~|res;
                end
            end
        end
`ifdef ALU_MUL_EN
        else if (state == BUSY) begin
            if (mul_last) begin
                state     <= DONE;
                out_valid <= 1'b1;
                c         <= mul_prod[K-1:0];
                if (setf_q) begin
                    status[ST_V] <= |mul_prod[2*K-1:K];
                    status[ST_N] <= mul_prod[K-1];
                    status[ST_Z] <= ~|mul_prod[K-1:0];
                end
            end
        end
`endif
        else if ((state == DONE) && out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
        end
    end

endmodule

// File: doc/alu_exec_stage.md
Name: alu_exec_stage

Overview:
Execute stage directly downstream of the barrel-shift stage. Consumes operand A and the shifted operand B, performs the selected ALU operation, and registers result C and status flags {V,N,Z}. A valid/ready handshake on both sides allows multi-cycle operations; the optional iterative multiplier is the only multi-cycle op.

Parameters:
K, 16, datapath width of ain, bin and c
MUL_CYC, K, iterations for multiply (one bit of bin per cycle)

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
in_valid  input  1  upstream operands/op valid
in_ready  output  1  stage can accept operands this cycle
ain  input  K  operand A
bin  input  K  operand B, already shifted
op  input  3  000 ADD, 001 SUB, 010 AND, 011 MVN (~bin), 100 MUL, 101-111 reserved
setf  input  1  update status with this op's flags
out_valid  output  1  c holds an unconsumed result
out_ready  input  1  downstream consumes c
c  output  K  registered result
status  output  3  {V,N,Z}, registered

Behaviour:
- Reset (async, immediate): state=IDLE, c=0, status=3'b000, out_valid=0, multiply aborted, latched operands cleared; in_ready=1 once reset deasserts.
- States: IDLE, BUSY (multiply only), DONE.
- Accept = in_valid && in_ready. in_ready = (state==IDLE) || (state==DONE && out_ready); combinational, so back-to-back single-cycle ops sustain 1 op/cycle.
- Single-cycle ops: on the accept edge c is written, status conditionally written, state→DONE, out_valid=1 (latency 1).
- ADD/SUB: K-bit two's complement, carry discarded. V = signed overflow (ADD: same-sign operands, different-sign result; SUB: different-sign operands, result sign != ain sign). AND/MVN: V=0.
- N=c[K-1]; Z=(c==0).
- status is written only when the latched setf=1, at the same edge c is written; otherwise it holds its value.
- DONE: c/status held stable while out_valid && !out_ready. out_ready with no new accept → IDLE, out_valid=0. out_ready with new accept → new result/state per new op.
- in_valid while in_ready=0: ignored. Upstream holds its inputs.
- Reserved ops (and 100 without the macro): single-cycle, c=0, V=0, N=0, Z=1.
- out_ready while out_valid=0: no effect.

Optional Feature:
ALU_MUL_EN defined: op 100 is an unsigned shift-add multiply. The accept edge latches ain/bin, clears the accumulator, and sets state→BUSY, in_ready=0. Each of the next MUL_CYC edges processes one bin bit LSB-first. The final edge writes c=product[K-1:0] and sets state→DONE, out_valid=1, so out_valid rises MUL_CYC cycles after accept. V=1 if product[2K-1:K]!=0; N and Z follow c. Reset during BUSY aborts.
ALU_MUL_EN undefined: no BUSY state, no multiplier logic; op 100 behaves as reserved.

Decomposition:
- Package alu_pkg: op encodings (ALU_ADD..ALU_MUL), state enum {IDLE,BUSY,DONE}, status bit indices (ST_V=2, ST_N=1, ST_Z=0).
- One sub-module, mul_iter: start/done shift-add multiplier holding accumulator, multiplicand and counter. Instantiated only under ALU_MUL_EN.

Test Plan:
- Assert reset mid-MUL (cycle 5 of 16) → out_valid=0, c=16'h0000, status=3'b000 immediately; in_ready=1 after release; no stale result appears.
- ADD ain=16'h7FFF bin=16'h0001 setf=1 → next edge out_valid=1, c=16'h8000, status=3'b110.
- After the ADD above, SUB ain=16'h0005 bin=16'h0005 setf=0 → c=16'h0000, status stays 3'b110.
- AND ain=16'hF0F0 bin=16'h0FF0 with out_ready=0 for 3 cycles → c=16'h00F0 held, in_ready=0. Raise out_ready with in_valid (MVN bin=16'h00FF) → same edge accepts, next c=16'hFF00, out_valid stays 1.
- ALU_MUL_EN: MUL 16'd3*16'd7 setf=1 → out_valid after 16 cycles, c=16'd21, status=3'b000. MUL 16'h0100*16'h0100 → c=16'h0000, status=3'b101.
- No ALU_MUL_EN: op=100 ain=16'h1234 bin=16'h0002 setf=1 → 1-cycle latency, c=16'h0000, status=3'b001. op=111 gives the same.
